// File: rtl/alut_age_checker15_if.sv
// Signal bundle between the ALUT age checker, its register bank and the shared address memory.
// Protocol: there is no valid/ready pair here. `command` is a one-cycle pulse taken only when the
// checker is idle; mem_rd15 returns mem_rdata15 on the following cycle; mem_wr15 writes on the strobe edge.
interface alut_age_checker15_if #(parameter int AW15 = 8);
  logic [1:0]      command;
  logic [31:0]     best_bfr_age15;
  logic [31:0]     curr_time15;
  logic            add_check_active15;
  logic [AW15-1:0] mem_addr15;
  logic            mem_rd15;
  logic [82:0]     mem_rdata15;
  logic            mem_wr15;
  logic [82:0]     mem_wdata15;
  logic            age_check_active15;
  logic            inval_in_prog15;
  logic [47:0]     lst_inv_addr_cmd15;
  logic [1:0]      lst_inv_port_cmd15;
  logic [AW15:0]   inval_cnt15;
  logic [2:0]      state_dbg;

  modport slave (
    input  command, best_bfr_age15, curr_time15, add_check_active15, mem_rdata15,
    output mem_addr15, mem_rd15, mem_wr15, mem_wdata15, age_check_active15,
           inval_in_prog15, lst_inv_addr_cmd15, lst_inv_port_cmd15, inval_cnt15, state_dbg
  );

  modport master (
    output command, best_bfr_age15, curr_time15, add_check_active15, mem_rdata15,
    input  mem_addr15, mem_rd15, mem_wr15, mem_wdata15, age_check_active15,
           inval_in_prog15, lst_inv_addr_cmd15, lst_inv_port_cmd15, inval_cnt15, state_dbg
  );
endinterface

// File: rtl/alut_age_checker15.sv
// ALUT age checker: walks the address memory once per command and clears the valid bit of
// aged entries (command 01) or of every valid entry (command 10).
module alut_age_checker15 #(
  parameter int DEPTH15 = 256,
  parameter int AW15    = 8
) (
  input  logic                   pclk15,
  input  logic                   p_reset15,
  alut_age_checker15_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW15-1:0] idx_q;
  logic            mode_q;           // 1 = flush, 0 = age
  logic [AW15:0]   cnt_q;
  logic [AW15:0]   inval_cnt_q;
  logic [82:0]     entry_q;
  logic [47:0]     lst_addr_q;
  logic [1:0]      lst_port_q;
  logic            active_q;

  logic [31:0]     age;
  logic            hit;
  logic            last_idx;
  logic            cmd_go;

  always_comb begin
    // Unsigned modular subtraction makes a wrapped timestamp still yield the true age.
    age      = bus.curr_time15 - bus.mem_rdata15[31:0];
    hit      = bus.mem_rdata15[82] & (mode_q | (age > bus.best_bfr_age15));
    last_idx = (idx_q == AW15'(DEPTH15 - 1));
    cmd_go   = (bus.command == 2'b01) || (bus.command == 2'b10);

    state_d         = state_q;
    bus.mem_rd15    = 1'b0;
    bus.mem_wr15    = 1'b0;
    bus.mem_addr15  = '0;
    bus.mem_wdata15 = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_go) state_d = bus.add_check_active15 ? S_WAIT : S_READ;
      end
      S_WAIT: begin
        if (!bus.add_check_active15) state_d = S_READ;
      end
      S_READ: begin
        bus.mem_rd15   = 1'b1;
        bus.mem_addr15 = idx_q;
        state_d        = S_CHECK;
      end
      S_CHECK: begin
        if (hit)           state_d = S_WRITE;
        else if (last_idx) state_d = S_DONE;
        else               state_d = S_READ;
      end
      S_WRITE: begin
        bus.mem_wr15    = 1'b1;
        bus.mem_addr15  = idx_q;
        bus.mem_wdata15 = {1'b0, entry_q[81:0]};
        state_d         = last_idx ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk15) begin
    if (p_reset15) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      inval_cnt_q <= '0;
      entry_q     <= '0;
      lst_addr_q  <= '0;
      lst_port_q  <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Registered from next state so the flag lines up exactly with READ/CHECK/WRITE.
      active_q <= (state_d == S_READ) || (state_d == S_CHECK) || (state_d == S_WRITE);
      case (state_q)
        S_IDLE: begin
          if (cmd_go) begin
            mode_q <= (bus.command == 2'b10);
            idx_q  <= '0;
            cnt_q  <= '0;
          end
        end
        S_CHECK: begin
          entry_q <= bus.mem_rdata15;
          if (hit) begin
            lst_addr_q <= bus.mem_rdata15[79:32];
            lst_port_q <= bus.mem_rdata15[81:80];
            cnt_q      <= cnt_q + (AW15+1)'(1);
          end else if (!last_idx) begin
            idx_q <= idx_q + AW15'(1);
          end
        end
        S_WRITE: begin
          if (!last_idx) idx_q <= idx_q + AW15'(1);
        end
        S_DONE:  inval_cnt_q <= cnt_q;
        default: ;
      endcase
    end
  end

  assign bus.age_check_active15 = active_q;
  assign bus.inval_in_prog15    = active_q;
  assign bus.lst_inv_addr_cmd15 = lst_addr_q;
  assign bus.lst_inv_port_cmd15 = lst_port_q;
  assign bus.inval_cnt15        = inval_cnt_q;
  assign bus.state_dbg          = state_q;

endmodule

// File: tb/tb_alut_age_checker15.sv
// Bench for alut_age_checker15: behavioural memory, reference scan model feeding an expected-write queue.
module tb_alut_age_checker15;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  // clock / reset
  logic pclk15 = 1'b0;
  logic p_reset15;
  always #5 pclk15 = ~pclk15;

  alut_age_checker15_if #(.AW15(AW)) bus();
  alut_age_checker15 #(.DEPTH15(DEPTH), .AW15(AW)) dut (
    .pclk15   (pclk15),
    .p_reset15(p_reset15),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // memory model: preload port, DUT write port, one-cycle read latency
  logic [82:0]   mem [DEPTH];
  logic          pre_we  = 1'b0;
  logic          pre_clr = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [82:0]   pre_data = '0;

  always @(posedge pclk15) begin
    if (pre_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_wr15) begin
      mem[bus.mem_addr15] <= bus.mem_wdata15;
    end
    if (bus.mem_rd15) bus.mem_rdata15 <= mem[bus.mem_addr15];
  end

  // scoreboard
  logic [AW+82:0] exp_q[$];
  logic [47:0]    exp_lst_addr = '0;
  logic [1:0]     exp_lst_port = '0;

  // advance one cycle and check memory-side behaviour at the sampling edge
  task automatic tick();
    logic [AW+82:0] exp;
    @(negedge pclk15);
    if (mon_en) begin
      if (bus.mem_rd15 || bus.mem_wr15) begin
        checks++;
        if (bus.mem_rd15 && bus.mem_wr15) begin
          errors++;
          $display("FAIL strobe_overlap: got rd=%0b wr=%0b expected never both", bus.mem_rd15, bus.mem_wr15);
        end
      end else if (bus.mem_addr15 !== '0) begin
        errors++;
        $display("FAIL idle_addr: got %0h expected 0", bus.mem_addr15);
      end
      if (bus.mem_wr15) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_write: got unexpected write addr %0h data %0h expected no write",
                   bus.mem_addr15, bus.mem_wdata15);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.mem_addr15, bus.mem_wdata15} !== exp) begin
            errors++;
            $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                     bus.mem_addr15, bus.mem_wdata15, exp[AW+82:83], exp[82:0]);
          end
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic poke(input int addr, input logic [82:0] data);
    pre_addr = AW'(addr);
    pre_data = data;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic clear_mem();
    pre_clr = 1'b1;
    tick();
    pre_clr = 1'b0;
  endtask

  // reference scan over the current memory and thresholds; pushes expected writes
  task automatic model_scan(input logic flush, output int hits);
    logic [82:0] e;
    logic [31:0] age;
    hits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e   = mem[i];
      age = bus.curr_time15 - e[31:0];
      if (e[82] && (flush || age > bus.best_bfr_age15)) begin
        exp_q.push_back({AW'(i), 1'b0, e[81:0]});
        hits++;
        exp_lst_addr = e[79:32];
        exp_lst_port = e[81:80];
      end
    end
  endtask

  task automatic pulse(input logic [1:0] cmd);
    bus.command = cmd;
    tick();
    bus.command = 2'b00;
  endtask

  // follow an active scan to IDLE and check its results
  task automatic finish_scan(input int exp_hits, input int exp_flag_cycles, input string name);
    int  n = 0;
    logic flag_bad = 1'b0;
    while (bus.age_check_active15 === 1'b1 && n < 4000) begin
      if (bus.inval_in_prog15 !== 1'b1) flag_bad = 1'b1;
      n++;
      tick();
    end
    tick();
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d active cycles expected scan to end", name, n);
    end
    if (exp_flag_cycles >= 0) begin
      checks++;
      if (n != exp_flag_cycles) begin
        errors++;
        $display("FAIL %s_flag_cycles: got %0d expected %0d", name, n, exp_flag_cycles);
      end
    end
    checks++;
    if (flag_bad || bus.inval_in_prog15 !== 1'b0) begin
      errors++;
      $display("FAIL %s_inval_in_prog: got %0b expected to track age_check_active", name, bus.inval_in_prog15);
    end
    checks++;
    if (bus.inval_cnt15 !== (AW+1)'(exp_hits)) begin
      errors++;
      $display("FAIL %s_inval_cnt: got %0d expected %0d", name, bus.inval_cnt15, exp_hits);
    end
    checks++;
    if (bus.state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s_state: got %0d expected 0", name, bus.state_dbg);
    end
    checks++;
    if (bus.lst_inv_addr_cmd15 !== exp_lst_addr || bus.lst_inv_port_cmd15 !== exp_lst_port) begin
      errors++;
      $display("FAIL %s_lst_inv: got %0h/%0d expected %0h/%0d", name, bus.lst_inv_addr_cmd15,
               bus.lst_inv_port_cmd15, exp_lst_addr, exp_lst_port);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic bad = 1'b0;
    p_reset15 = 1'b1;
    ticks(3);
    p_reset15 = 1'b0;
    mon_en    = 1'b1;
    clear_mem();
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_rd15 !== 1'b0 || bus.mem_wr15 !== 1'b0 || bus.mem_wdata15 !== '0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_strobes: got a memory strobe expected none");
    end
    checks++;
    if (bus.age_check_active15 !== 1'b0 || bus.inval_in_prog15 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got %0b%0b expected 00", bus.age_check_active15, bus.inval_in_prog15);
    end
    checks++;
    if (bus.lst_inv_addr_cmd15 !== 48'h0 || bus.lst_inv_port_cmd15 !== 2'd0 || bus.inval_cnt15 !== '0) begin
      errors++;
      $display("FAIL reset_status: got %0h/%0d/%0d expected 0/0/0", bus.lst_inv_addr_cmd15,
               bus.lst_inv_port_cmd15, bus.inval_cnt15);
    end
    checks++;
    if (bus.state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", bus.state_dbg);
    end
  endtask

  task automatic test_age();
    int hits;
    clear_mem();
    poke(5, {1'b1, 2'd2, 48'h0011_2233_4455, 32'd100});
    poke(6, {1'b1, 2'd1, 48'h0000_0000_0666, 32'd250});
    bus.curr_time15    = 32'd300;
    bus.best_bfr_age15 = 32'd150;
    model_scan(1'b0, hits);
    pulse(2'b01);
    finish_scan(hits, 2*DEPTH + 1, "age_hit");
    checks++;
    if (mem[5][82] !== 1'b0 || mem[6][82] !== 1'b1 || exp_lst_addr !== 48'h0011_2233_4455) begin
      errors++;
      $display("FAIL age_hit_mem: got e5v=%0b e6v=%0b expected 0 1", mem[5][82], mem[6][82]);
    end
    // age exactly equal to threshold must not invalidate
    poke(5, {1'b1, 2'd2, 48'h0011_2233_4455, 32'd100});
    bus.best_bfr_age15 = 32'd200;
    model_scan(1'b0, hits);
    pulse(2'b01);
    finish_scan(hits, 2*DEPTH, "age_equal");
  endtask

  task automatic test_wrap();
    int hits;
    clear_mem();
    poke(9,  {1'b1, 2'd1, 48'ha1a2_a3a4_a5a6, 32'hffff_fff0});
    poke(10, {1'b1, 2'd3, 48'hb1b2_b3b4_b5b6, 32'h0000_0008});
    bus.curr_time15    = 32'h10;
    bus.best_bfr_age15 = 32'd16;
    model_scan(1'b0, hits);
    pulse(2'b01);
    finish_scan(hits, 2*DEPTH + 1, "wrap");
    // max threshold ages nothing, even a very old entry
    poke(9, {1'b1, 2'd1, 48'ha1a2_a3a4_a5a6, 32'h0000_0011});
    bus.best_bfr_age15 = 32'hffff_ffff;
    model_scan(1'b0, hits);
    pulse(2'b01);
    finish_scan(hits, 2*DEPTH, "max_thresh");
  endtask

  task automatic test_flush();
    int hits;
    clear_mem();
    poke(0,   {1'b1, 2'd0, 48'h0000_0000_0a00, 32'd5});
    poke(3,   {1'b0, 2'd3, 48'hdead_beef_0003, 32'd5});
    poke(7,   {1'b1, 2'd1, 48'h0000_0000_0a07, 32'd6});
    poke(255, {1'b1, 2'd3, 48'hcafe_f00d_00ff, 32'd7});
    bus.curr_time15    = 32'd7;
    bus.best_bfr_age15 = 32'hffff_ffff;
    model_scan(1'b1, hits);
    pulse(2'b10);
    finish_scan(hits, 2*DEPTH + 3, "flush");
  endtask

  task automatic test_wait_and_drop();
    int   hits;
    logic bad = 1'b0;
    clear_mem();
    poke(20, {1'b1, 2'd2, 48'h0000_0000_0020, 32'd0});
    poke(21, {1'b1, 2'd1, 48'h0000_0000_0021, 32'd1000});
    bus.curr_time15    = 32'd1000;
    bus.best_bfr_age15 = 32'd500;
    model_scan(1'b0, hits);
    bus.add_check_active15 = 1'b1;
    pulse(2'b01);
    for (int i = 0; i < 19; i++) begin
      if (bus.state_dbg !== 3'd1 || bus.mem_rd15 !== 1'b0 || bus.age_check_active15 !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL wait_hold: got activity while address checker active expected none");
    end
    bus.add_check_active15 = 1'b0;
    tick();
    checks++;
    if (bus.mem_rd15 !== 1'b1 || bus.mem_addr15 !== '0 || bus.age_check_active15 !== 1'b1) begin
      errors++;
      $display("FAIL wait_release: got rd=%0b addr=%0h act=%0b expected 1 0 1",
               bus.mem_rd15, bus.mem_addr15, bus.age_check_active15);
    end
    ticks(40);
    bus.add_check_active15 = 1'b1;
    pulse(2'b10);
    ticks(10);
    bus.add_check_active15 = 1'b0;
    finish_scan(hits, -1, "wait_scan");
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.age_check_active15 !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad || mem[21][82] !== 1'b1) begin
      errors++;
      $display("FAIL dropped_cmd: got rescan=%0b e21v=%0b expected 0 1", bad, mem[21][82]);
    end
  endtask

  task automatic test_reset_mid();
    int hits;
    int n = 0;
    for (int i = 0; i < DEPTH; i++) poke(i, {1'b1, 2'(i), 48'(i) + 48'h1000, 32'(i)});
    model_scan(1'b1, hits);
    pulse(2'b10);
    while (!(bus.mem_rd15 === 1'b1 && bus.mem_addr15 === AW'(100)) && n < 1000) begin
      n++;
      tick();
    end
    checks++;
    if (n >= 1000 || exp_q.size() != DEPTH - 100 || exp_q[0][AW+82:83] !== AW'(100)) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d outstanding after %0d cycles expected %0d",
               exp_q.size(), n, DEPTH - 100);
    end
    p_reset15 = 1'b1;
    exp_q.delete();
    exp_lst_addr = '0;
    exp_lst_port = '0;
    tick();
    checks++;
    if (bus.state_dbg !== 3'd0 || bus.age_check_active15 !== 1'b0 || bus.inval_cnt15 !== '0 ||
        bus.lst_inv_addr_cmd15 !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid_state: got st=%0d act=%0b cnt=%0d lst=%0h expected 0 0 0 0",
               bus.state_dbg, bus.age_check_active15, bus.inval_cnt15, bus.lst_inv_addr_cmd15);
    end
    p_reset15 = 1'b0;
    ticks(10);
    checks++;
    if (mem[99][82] !== 1'b0 || mem[100][82] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mem: got e99v=%0b e100v=%0b expected 0 1", mem[99][82], mem[100][82]);
    end
    // recovery: flush the remaining valid entries back to back
    model_scan(1'b1, hits);
    pulse(2'b10);
    finish_scan(hits, 2*DEPTH + DEPTH - 100, "recover");
  endtask

  initial begin
    bus.command            = 2'b00;
    bus.best_bfr_age15     = '0;
    bus.curr_time15        = '0;
    bus.add_check_active15 = 1'b0;
    p_reset15              = 1'b1;
    test_reset();
    test_age();
    test_wrap();
    test_flush();
    test_wait_and_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alut_age_checker15.md
Name: alut_age_checker15

Overview:
- Downstream consumer of the ALUT register bank.
- Executes `command` pulses: 2'b01 invalidates aged entries, 2'b10 flushes all entries.
- Walks the ALUT address memory once per command and invalidates qualifying entries.
- Returns `age_check_active15`, `inval_in_prog15`, `lst_inv_addr_cmd15` and `lst_inv_port_cmd15` to the register bank.
- Shares the memory with the address checker; never starts while `add_check_active15` is high.

Parameters:
- DEPTH15, 256, number of memory entries scanned.
- AW15, 8, memory address width; DEPTH15 = 2**AW15.

Ports:
- pclk15  in  1  clock
- p_reset15  in  1  reset
- command  in  2  one-cycle command pulse from the register bank (01 age, 10 flush, 00/11 none)
- best_bfr_age15  in  32  age threshold
- curr_time15  in  32  free-running time
- add_check_active15  in  1  address checker owns the memory
- mem_addr15  out  AW15  memory address
- mem_rd15  out  1  read strobe; data returns next cycle
- mem_rdata15  in  83  entry: [82] valid, [81:80] port, [79:32] mac addr, [31:0] timestamp
- mem_wr15  out  1  write strobe
- mem_wdata15  out  83  write data
- age_check_active15  out  1  scan in progress
- inval_in_prog15  out  1  scan in progress (register bank status[1])
- lst_inv_addr_cmd15  out  48  address of last invalidated entry
- lst_inv_port_cmd15  out  2  port of last invalidated entry
- inval_cnt15  out  AW15+1  entries invalidated by the last completed scan

Behaviour:
- One clock; reset is synchronous and active-high (`p_reset15` sampled on posedge `pclk15`).
- Reset values: all outputs 0; FSM in IDLE; index 0; mode 0.
- States: IDLE, WAIT, READ, CHECK, WRITE, DONE.
- IDLE:
  - On `command` 01 or 10, latch mode (age/flush).
  - Go to WAIT if `add_check_active15` = 1, else READ with index = 0 and the working count cleared.
  - Commands 00 and 11 are ignored.
- WAIT: stay while `add_check_active15` = 1; then go to READ.
- `age_check_active15` and `inval_in_prog15` are registered. Both are high in READ, CHECK and WRITE, and low in IDLE, WAIT and DONE.
- READ: `mem_rd15` = 1, `mem_addr15` = index; go to CHECK.
- CHECK (`mem_rdata15` valid):
  - age = curr_time15 - timestamp, modulo 2^32, so wraparound is handled.
  - Age mode: hit = valid & (age > best_bfr_age15). The comparison is strict, so best_bfr_age15 = 32'hffff_ffff never ages anything.
  - Flush mode: hit = valid.
  - Hit: register `lst_inv_addr_cmd15`/`lst_inv_port_cmd15` from the entry, increment the working count, go to WRITE.
  - No hit: if index = DEPTH15-1 go to DONE, else increment index and go to READ.
- WRITE:
  - `mem_wr15` = 1, `mem_addr15` = index, `mem_wdata15` = entry with bit 82 cleared; other bits unchanged.
  - Then DONE if index = DEPTH15-1, else increment index and go to READ.
- DONE: `inval_cnt15` <= working count (held until the next DONE); go to IDLE.
- Per-entry timing: 2 cycles without a hit, 3 cycles with a hit.
- Scan duration: 2*DEPTH15 + hits + 2 cycles from command to IDLE, not counting WAIT.
- `command` pulses arriving in any state other than IDLE are dropped.
- `add_check_active15` rising mid-scan is ignored. The address checker must observe `age_check_active15` and hold off.
- `mem_rd15` and `mem_wr15` are never high in the same cycle. Both are low outside READ/WRITE, and `mem_addr15` is 0 there.
- `lst_inv_*` outputs hold their value between hits and across scans; only reset clears them.
- Reset mid-scan: within the same cycle edge, return to IDLE with no further memory write and flags low. `inval_cnt15` is cleared.
- `best_bfr_age15` and `curr_time15` are sampled in each CHECK cycle, not latched at start.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, no memory strobes.
- Preload entry 5 = {valid, port 2, addr 48'h0011_2233_4455, ts 100}; curr_time15 = 300, best_bfr_age15 = 150, command 01 -> entry 5 rewritten with bit 82 clear; `lst_inv_addr_cmd15` = 48'h0011_2233_4455, port 2; `inval_cnt15` = 1; flags high for 2*256+1 cycles.
- Same memory with best_bfr_age15 = 200 (age 200, not >) -> no write; `inval_cnt15` = 0.
- Wraparound: ts = 32'hffff_fff0, curr_time15 = 32'h10, best_bfr_age15 = 16 -> age 32, entry invalidated.
- Flush (command 10) with 3 valid entries at 0, 7, 255 -> three writes; `lst_inv_addr_cmd15` = entry 255 addr; `inval_cnt15` = 3.
- command 01 while `add_check_active15` high for 20 cycles -> first READ one cycle after it drops. Second command mid-scan -> ignored. Reset at entry 100 -> IDLE, no further writes.
